mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Single-port memory arbiter that lets the RV32IM_Zbb core's instruction-fetch port and data port share one unified synchronous RAM. It sits between the `cpu` memory interfaces and the RAM in the top module. Each cycle it grants at most one access, with data having priority and bounded starvation protection for fetch. It returns read data one cycle later, tagged to the owning port, and raises `stall_o` so the pipeline holds while a request is waiting.

## Interface
- `MEM_AW`, 12: RAM word-address width; RAM depth is 2^MEM_AW words.
- `STARVE_LIMIT`, 3: number of consecutive cycles fetch may be denied before it overrides data priority; range 1..15.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `i_req_i`  in  1  fetch request.
- `i_addr_i`  in  32  fetch byte address.
- `i_gnt_o`  out  1  fetch granted this cycle.
- `i_rvalid_o`  out  1  fetch data valid this cycle.
- `i_rdata_o`  out  32  fetched word, held until the next fetch response.
- `d_req_i`  in  1  data request.
- `d_we_i`  in  4  byte write enables; 0 means a read.
- `d_addr_i`  in  32  data byte address.
- `d_wdata_i`  in  32  store data, lane-aligned.
- `d_gnt_o`  out  1  data granted this cycle.
- `d_rvalid_o`  out  1  load data valid; never asserted for writes.
- `d_rdata_o`  out  32  loaded word, held until the next data response.
- `mem_en_o`  out  1  RAM enable.
- `mem_we_o`  out  4  RAM byte write enables.
- `mem_addr_o`  out  MEM_AW  RAM word address, equal to addr[MEM_AW+1:2].
- `mem_wdata_o`  out  32  RAM write data.
- `mem_rdata_i`  in  32  RAM read data, valid one cycle after an enabled read.
- `stall_o`  out  1  high when any asserted request is not granted this cycle.

## Operation
- **Grant.** Grant is combinational from the current requests and the registered starvation count.
  - Only one requester: it is granted.
  - Both requesting: data wins, unless `starve_cnt == STARVE_LIMIT`, in which case fetch wins.
- **RAM port.**
  - The granted port drives the RAM port in the same cycle; `mem_en_o = i_gnt_o | d_gnt_o`.
  - A fetch grant forces `mem_we_o = 0`.
  - When nothing is granted, `mem_we_o`, `mem_addr_o` and `mem_wdata_o` are 0.
- **Response FSM** (`resp_q`), one transition per cycle:
  - States are `R_NONE`, `R_I` and `R_D`.
  - The next state is `R_I` on a fetch grant, `R_D` on a data read grant, and `R_NONE` otherwise (idle or data write).
- **Read response.**
  - In `R_I`: `i_rvalid_o = 1`, and `i_rdata_q <= mem_rdata_i`.
  - In `R_D`: `d_rvalid_o = 1`, and `d_rdata_q <= mem_rdata_i`.
  - `i_rdata_o` and `d_rdata_o` are driven combinationally from `mem_rdata_i` while their rvalid is high, and from the hold register otherwise. This keeps read latency at exactly 1 while the value stays stable for a stalled pipeline.
- **Starvation counter** (`starve_cnt`, 4 bits):
  - Increments when `i_req_i & ~i_gnt_o`, saturating at STARVE_LIMIT.
  - Clears on `i_gnt_o` or when `~i_req_i`.
- **Alignment.** Address bits [1:0] and bits above MEM_AW+1 are ignored. The RAM wraps modulo its depth.
- **Back-to-back accesses.** A new grant may issue in the same cycle as the previous response; the design is fully pipelined with throughput 1 access per cycle.
- **Request stability.** Requesters must hold req, addr, we and wdata stable until granted. Dropping a request before grant is legal and produces no access.

## Timing
- All outputs reset to 0:
  - `resp_q = R_NONE`, `starve_cnt = 0`, and both hold registers 0.
  - Combinational outputs evaluate to 0 when no requests are present.
- Latency:
  - Grant occurs in cycle N.
  - The RAM samples the access at the edge ending cycle N.
  - rvalid and rdata appear in cycle N+1.
  - A write takes effect at the edge ending cycle N.
- Simultaneous requests:
  - Data is served in cycle N and fetch in cycle N+1, unless starvation forces fetch first.
  - Fetch waits at most STARVE_LIMIT cycles.
- Reset asserted mid-operation:
  - The pending response is dropped and rvalid is deasserted immediately (asynchronously).
  - The hold registers clear.
  - The RAM contents are unaffected.
- `stall_o = (i_req_i & ~i_gnt_o) | (d_req_i & ~d_gnt_o)`; it is combinational with no added latency.

## Structure
- Shared package `mem_arb_pkg`:
  - `resp_e` enum {`R_NONE`, `R_I`, `R_D`}.
  - Constants `WORD_W = 32` and `BE_W = 4`.
- One natural sub-module, `mem_arb_prio`: a combinational two-input priority selector with starvation override. It takes the requests, `starve_cnt` and STARVE_LIMIT, and produces the grants.
- The FSM, counter and hold registers live in the top of `mem_arbiter`.

## Test plan
- **Fetch only.** Stimulus: `i_req_i = 1`, addr 0x10, RAM[4] = 0xDEADBEEF. Required: grant in the same cycle, `mem_addr_o = 4`, `i_rvalid_o = 1` with `i_rdata_o = 0xDEADBEEF` one cycle later, `stall_o = 0`.
- **Store then load.**
  - Stimulus: data write with `d_we_i = 4'b0011`, addr 0x20, wdata 0x1234ABCD onto an old value of 0xFFFFFFFF.
  - Then: a data read of addr 0x20.
  - Required: no `d_rvalid_o` on the write; the read returns 0xFFFFABCD.
- **Simultaneous requests.** Stimulus: both ports request, STARVE_LIMIT = 3. Required: data granted in cycle 0, `stall_o = 1`; fetch granted in cycle 1; rvalids arrive on the correct ports in cycles 1 and 2.
- **Starvation override.** Stimulus: data requests every cycle while fetch also requests. Required: fetch is granted in cycle 3 and data is denied in that cycle; the counter returns to 0.
- **Hold on stall.** Stimulus: fetch response 0x00000013, then no fetches for 5 cycles while data reads 0x55. Required: `i_rdata_o` stays 0x00000013 and `d_rdata_o` shows 0x55.
- **Reset mid-operation.** Stimulus: assert `rst_n` low in the cycle after a read grant. Required: rvalid is 0 immediately, the hold registers are 0, and no response appears after `rst_n` is released.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and constants for the memory arbiter
package mem_arb_pkg;
  localparam int WORD_W = 32;
  localparam int BE_W = 4;
  typedef enum logic [1:0] {R_NONE, R_I, R_D} resp_e;
endpackage

// File: rtl/mem_arb_prio.sv
// mem_arb_prio: data-priority two-way selector with fetch starvation override
module mem_arb_prio #(
  parameter int STARVE_LIMIT = 3
) (
  input  logic       i_req,
  input  logic       d_req,
  input  logic [3:0] starve_cnt,
  output logic       i_gnt,
  output logic       d_gnt
);
  localparam logic [3:0] LIM = 4'(STARVE_LIMIT);
  logic starved;
  always_comb begin
    starved = starve_cnt == LIM;
    i_gnt = i_req & (~d_req | starved);
    d_gnt = d_req & ~(i_req & starved);
  end
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one synchronous RAM between fetch and data ports with 1-cycle read latency
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int MEM_AW = 12,
  parameter int STARVE_LIMIT = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_req_i,
  input  logic [31:0]       i_addr_i,
  output logic              i_gnt_o,
  output logic              i_rvalid_o,
  output logic [WORD_W-1:0] i_rdata_o,
  input  logic              d_req_i,
  input  logic [BE_W-1:0]   d_we_i,
  input  logic [31:0]       d_addr_i,
  input  logic [WORD_W-1:0] d_wdata_i,
  output logic              d_gnt_o,
  output logic              d_rvalid_o,
  output logic [WORD_W-1:0] d_rdata_o,
  output logic              mem_en_o,
  output logic [BE_W-1:0]   mem_we_o,
  output logic [MEM_AW-1:0] mem_addr_o,
  output logic [WORD_W-1:0] mem_wdata_o,
  input  logic [WORD_W-1:0] mem_rdata_i,
  output logic              stall_o
);
  localparam logic [3:0] LIM = 4'(STARVE_LIMIT);
  resp_e resp_q, resp_d;
  logic [3:0] starve_cnt;
  logic [WORD_W-1:0] i_rdata_q, d_rdata_q;
  logic unused_addr;
  mem_arb_prio #(.STARVE_LIMIT(STARVE_LIMIT)) u_prio (
    .i_req(i_req_i),
    .d_req(d_req_i),
    .starve_cnt(starve_cnt),
    .i_gnt(i_gnt_o),
    .d_gnt(d_gnt_o)
  );
  assign unused_addr = ^{i_addr_i[31:MEM_AW+2], i_addr_i[1:0], d_addr_i[31:MEM_AW+2], d_addr_i[1:0]};
  always_comb begin
    mem_en_o = i_gnt_o | d_gnt_o;
    mem_we_o = d_gnt_o ? d_we_i : '0;
    mem_addr_o = d_gnt_o ? d_addr_i[MEM_AW+1:2] : i_gnt_o ? i_addr_i[MEM_AW+1:2] : '0;
    mem_wdata_o = d_gnt_o ? d_wdata_i : '0;
    stall_o = (i_req_i & ~i_gnt_o) | (d_req_i & ~d_gnt_o);
    resp_d = i_gnt_o ? R_I : (d_gnt_o && d_we_i == '0) ? R_D : R_NONE;
    i_rvalid_o = resp_q == R_I;
    d_rvalid_o = resp_q == R_D;
    i_rdata_o = i_rvalid_o ? mem_rdata_i : i_rdata_q;
    d_rdata_o = d_rvalid_o ? mem_rdata_i : d_rdata_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      resp_q <= R_NONE;
      starve_cnt <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      resp_q <= resp_d;
      starve_cnt <= (i_req_i & ~i_gnt_o) ? (starve_cnt == LIM ? starve_cnt : starve_cnt + 4'd1) : '0;
      if (i_rvalid_o) i_rdata_q <= mem_rdata_i;
      if (d_rvalid_o) d_rdata_q <= mem_rdata_i;
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: random and directed checks of mem_arbiter against a transaction-level model
module tb_mem_arbiter;
  localparam int AW = 12;
  localparam int LIMIT = 3;
  logic clk = 0, rst_n = 0;
  logic i_req = 0, d_req = 0;
  logic [31:0] i_addr = 0, d_addr = 0, d_wdata = 0;
  logic [3:0] d_we = 0;
  logic i_gnt, i_rvalid, d_gnt, d_rvalid, mem_en, stall;
  logic [31:0] i_rdata, d_rdata, mem_wdata, mem_rdata;
  logic [3:0] mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0] ram [1<<AW];
  logic [31:0] exp_mem [1<<AW];
  int n_cmp = 0, n_err = 0;
  int m_pend = 0, m_wait = 0;
  logic [31:0] m_pend_data = 0, m_ihold = 0, m_dhold = 0;
  logic e_ig, e_dg, e_stall;
  logic [3:0] e_we;
  logic [AW-1:0] e_addr;
  logic [31:0] e_wd;
  logic ig, dg;

  mem_arbiter #(.MEM_AW(AW), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req_i(i_req), .i_addr_i(i_addr), .i_gnt_o(i_gnt), .i_rvalid_o(i_rvalid), .i_rdata_o(i_rdata),
    .d_req_i(d_req), .d_we_i(d_we), .d_addr_i(d_addr), .d_wdata_i(d_wdata),
    .d_gnt_o(d_gnt), .d_rvalid_o(d_rvalid), .d_rdata_o(d_rdata),
    .mem_en_o(mem_en), .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
    .mem_rdata_i(mem_rdata), .stall_o(stall)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (mem_en) begin
      for (int b = 0; b < 4; b++)
        if (mem_we[b]) ram[mem_addr][8*b+:8] <= mem_wdata[8*b+:8];
      mem_rdata <= ram[mem_addr];
    end

  task automatic check(string name, logic [127:0] act, logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_cycle();
    int idx;
    if (!rst_n) begin
      m_pend = 0; m_wait = 0; m_ihold = 0; m_dhold = 0;
      check("reset_rvalid", {i_rvalid, d_rvalid}, 0);
      check("reset_rdata", {i_rdata, d_rdata}, 0);
      return;
    end
    e_ig = i_req && (!d_req || m_wait >= LIMIT);
    e_dg = d_req && !e_ig;
    e_stall = (i_req && !e_ig) || (d_req && !e_dg);
    e_we = e_dg ? d_we : 4'd0;
    e_addr = e_dg ? d_addr[AW+1:2] : e_ig ? i_addr[AW+1:2] : '0;
    e_wd = e_dg ? d_wdata : 32'd0;
    check("grant_stall", {i_gnt, d_gnt, stall}, {e_ig, e_dg, e_stall});
    check("mem_port", {mem_en, mem_we, mem_addr}, {e_ig | e_dg, e_we, e_addr});
    if (!e_ig) check("mem_wdata", mem_wdata, e_wd);
    check("rvalid", {i_rvalid, d_rvalid}, {m_pend == 1, m_pend == 2});
    check("i_rdata", i_rdata, m_pend == 1 ? m_pend_data : m_ihold);
    check("d_rdata", d_rdata, m_pend == 2 ? m_pend_data : m_dhold);
    if (m_pend == 1) m_ihold = m_pend_data;
    if (m_pend == 2) m_dhold = m_pend_data;
    m_pend = 0;
    if (e_dg) begin
      idx = int'(d_addr[AW+1:2]);
      if (d_we == 0) begin
        m_pend = 2; m_pend_data = exp_mem[idx];
      end else
        for (int b = 0; b < 4; b++)
          if (d_we[b]) exp_mem[idx][8*b+:8] = d_wdata[8*b+:8];
    end else if (e_ig) begin
      m_pend = 1; m_pend_data = exp_mem[int'(i_addr[AW+1:2])];
    end
    m_wait = (i_req && !e_ig) ? (m_wait < LIMIT ? m_wait + 1 : LIMIT) : 0;
  endtask

  always @(negedge clk) model_cycle();

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic preset(int idx, logic [31:0] v);
    ram[idx] <= v;
    exp_mem[idx] = v;
  endtask

  initial begin
    for (int k = 0; k < (1 << AW); k++) preset(k, $urandom);
    preset(4, 32'hDEADBEEF);
    preset(8, 32'hFFFFFFFF);
    preset(12, 32'h00000013);
    preset(13, 32'h00000055);
    step(); step();
    check("reset_outputs", {i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata, mem_en, mem_we, mem_addr, mem_wdata, stall}, 0);
    rst_n = 1;
    step();
    i_req = 1; i_addr = 32'h10; #1;
    check("fetch_grant", {i_gnt, mem_addr, stall}, {1'b1, 12'd4, 1'b0});
    step(); i_req = 0; #1;
    check("fetch_resp", {i_rvalid, i_rdata}, {1'b1, 32'hDEADBEEF});
    step(); d_req = 1; d_we = 4'b0011; d_addr = 32'h20; d_wdata = 32'h1234ABCD; #1;
    check("store_grant", {d_gnt, mem_we}, {1'b1, 4'b0011});
    step(); d_we = 0; #1;
    check("store_no_rvalid", d_rvalid, 0);
    step(); d_req = 0; #1;
    check("load_after_store", {d_rvalid, d_rdata}, {1'b1, 32'hFFFFABCD});
    step(); i_req = 1; i_addr = 32'h10; d_req = 1; d_addr = 32'h24; #1;
    check("simul_c0", {i_gnt, d_gnt, stall}, 3'b011);
    step(); d_req = 0; #1;
    check("simul_c1", {i_gnt, d_gnt, i_rvalid, d_rvalid}, 4'b1001);
    step(); i_req = 0; #1;
    check("simul_c2", {i_rvalid, d_rvalid, i_rdata}, {2'b10, 32'hDEADBEEF});
    step(); i_req = 1; d_req = 1; d_addr = 32'h28;
    for (int k = 0; k <= LIMIT; k++) begin
      #1;
      check("starve_grant", {i_gnt, d_gnt}, k == LIMIT ? 2'b10 : 2'b01);
      step();
    end
    #1;
    check("starve_cleared", {i_gnt, d_gnt}, 2'b01);
    step(); i_req = 0; d_req = 0;
    step(); i_req = 1; i_addr = 32'h30;
    step(); i_req = 0; #1;
    check("hold_fetch", i_rdata, 32'h13);
    for (int k = 0; k < 5; k++) begin
      step(); d_req = 1; d_addr = 32'h34; #1;
      check("hold_i_stable", i_rdata, 32'h13);
      if (k > 0) check("hold_d_value", d_rdata, 32'h55);
    end
    step(); d_req = 0; #1;
    check("hold_final", {i_rdata, d_rdata}, {32'h13, 32'h55});
    step(); d_req = 1; d_addr = 32'h10;
    step(); d_req = 0; #1;
    rst_n = 0; #1;
    check("midreset", {i_rvalid, d_rvalid, i_rdata, d_rdata}, 0);
    @(posedge clk); @(posedge clk); #1 rst_n = 1;
    step();
    check("post_reset_idle", {i_rvalid, d_rvalid}, 0);
    d_req = 1; d_addr = 32'h10;
    step(); d_req = 0; #1;
    check("ram_kept", d_rdata, 32'hDEADBEEF);
    for (int n = 0; n < 3000; n++) begin
      ig = i_gnt; dg = d_gnt;
      step();
      if (!(i_req && !ig) || $urandom_range(0, 15) == 0) begin
        i_req = $urandom_range(0, 3) != 0;
        i_addr = $urandom;
      end
      if (!(d_req && !dg) || $urandom_range(0, 15) == 0) begin
        d_req = $urandom_range(0, 3) != 0;
        d_we = $urandom_range(0, 1) ? 4'd0 : 4'($urandom);
        d_addr = $urandom;
        d_wdata = $urandom;
      end
      #1;
    end
    i_req = 0; d_req = 0;
    step(); step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
